// File: rtl/fall_event_logger_pkg.sv
// ----------------------------------------------------------------------------
// fall_event_logger_pkg
//   Shared defaults and helpers for the falling-edge event logger.
//   - TS_W_DEF / DEPTH_DEF / CNT_W_DEF / HOLDOFF_DEF : default parameter values
//   - ts_t        : timestamp type at the default width
//   - clog2_depth : ceil(log2(depth)), usable in constant expressions
// ----------------------------------------------------------------------------
package fall_event_logger_pkg;

    localparam int unsigned TS_W_DEF    = 16;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned HOLDOFF_DEF = 4;

    typedef logic [TS_W_DEF-1:0] ts_t;

    function automatic int unsigned clog2_depth(input int unsigned depth);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(depth)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fall_event_logger_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with asynchronous active-low reset, synchronous flush
//   and a registered head-of-queue output.
//   Ports:
//     clk_i    : clock (rising edge)
//     rst_ni   : asynchronous active-low reset
//     flush_i  : synchronous empty; has priority over push/pop
//     push_i   : write wdata_i (accepted when not full, or full with pop)
//     wdata_i  : write data
//     pop_i    : discard head (ignored when empty)
//     rdata_o  : head entry, registered; holds last value while empty
//     full_o   : level == DEPTH
//     empty_o  : level == 0
//     level_o  : occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo
    import fall_event_logger_pkg::*;
#(
    parameter int unsigned WIDTH = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [clog2_depth(DEPTH):0]  level_o
);

    localparam int unsigned AW = clog2_depth(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            // Head register tracks mem[rd_ptr]; bypass the write data when the
            // new head is the entry being written this cycle.
            if (pop_ok) begin
                if (level_q > (AW+1)'(1)) begin
                    rdata_d = mem_q[rd_ptr_q + AW'(1)];
                end else if (push_ok) begin
                    rdata_d = wdata_i;
                end
            end else if (empty_o && push_ok) begin
                rdata_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign level_o = level_q;

endmodule

// File: rtl/fall_event_logger.sv
// ----------------------------------------------------------------------------
// fall_event_logger
//   Timestamps each rising edge of pulse_in (the detector's fall pulse) and
//   buffers records in a FIFO drained over valid/ready. Keeps a saturating
//   accepted-event counter and a sticky overflow flag.
//   Optional feature macro: FALL_EVENT_LOGGER_HOLDOFF_EN -- enforces a minimum
//   spacing of HOLDOFF cycles between accepted events.
//   Ports:
//     clk       : clock (rising edge)
//     reset_n   : asynchronous active-low reset
//     pulse_in  : event input (may be high for several cycles)
//     clear     : synchronous flush of FIFO, event_cnt and overflow
//     out_ready : reader accepts head record
//     out_valid : head record present
//     out_ts    : head record timestamp
//     level     : FIFO occupancy
//     event_cnt : records stored since reset/clear, saturating
//     overflow  : sticky, an event was dropped on a full FIFO
// ----------------------------------------------------------------------------
module fall_event_logger
    import fall_event_logger_pkg::*;
#(
    parameter int unsigned TS_W    = TS_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pulse_in,
    input  logic                         clear,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [TS_W-1:0]              out_ts,
    output logic [clog2_depth(DEPTH):0]  level,
    output logic [CNT_W-1:0]             event_cnt,
    output logic                         overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("HOLDOFF must be at least 1");
    end

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             pulse_d_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             event_raw;
    logic             event_ok;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    assign event_raw = pulse_in & ~pulse_d_q;
    assign pop       = out_valid & out_ready & ~clear;
    assign push      = event_ok & (~fifo_full | pop) & ~clear;
    assign drop      = event_ok & fifo_full & ~pop & ~clear;

`ifdef FALL_EVENT_LOGGER_HOLDOFF_EN
    localparam int unsigned HO_W = clog2_depth(HOLDOFF + 1);

    logic [HO_W-1:0] hold_q, hold_d;

    assign event_ok = event_raw & (hold_q == '0);

    always_comb begin
        hold_d = hold_q;
        if (clear) begin
            hold_d = '0;
        end else if (push) begin
            hold_d = HO_W'(HOLDOFF - 1);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign event_ok = event_raw;
`endif

    always_comb begin
        ts_d  = ts_q + TS_W'(1);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            pulse_d_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            pulse_d_q <= pulse_in;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (clear),
        .push_i  (push),
        .wdata_i (ts_q),
        .pop_i   (pop),
        .rdata_o (out_ts),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = ~fifo_empty;
    assign event_cnt = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/fall_event_logger.md
# fall_event_logger

Downstream consumer of the negative-edge pulse detector's `q` output. It converts each detected falling-edge event into a timestamped record and buffers records in a small FIFO. Records are drained over a valid/ready interface, which lets a slower reader (CPU bridge or UART formatter) collect edge times without losing events in bursts. It also keeps a saturating event counter and a sticky overflow flag.

## Interface
Parameters:
- `TS_W`, default 16: width of the free-running timestamp and of each record.
- `DEPTH`, default 8: FIFO depth in records; must be a power of two, ≥ 2.
- `CNT_W`, default 16: width of the accepted-event counter.
- `HOLDOFF`, default 4: minimum spacing in cycles between accepted events. Only used when `FALL_EVENT_LOGGER_HOLDOFF_EN` is defined.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pulse_in` in 1: event input, driven by the detector's `q`. It may be high for one or more cycles.
- `clear` in 1: synchronous flush. Empties the FIFO and clears `event_cnt` and `overflow`.
- `out_ready` in 1: the reader accepts the head record.
- `out_valid` out 1: the head record is present.
- `out_ts` out TS_W: timestamp of the head record.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `event_cnt` out CNT_W: number of records stored since reset or clear. Saturates at all-ones.
- `overflow` out 1: sticky. Set when an event is dropped because the FIFO is full.

## Operation
- Timestamp `ts`:
  - Free-running TS_W counter.
  - It is 0 in the first cycle after reset release and increments every cycle.
  - It wraps from 2^TS_W−1 to 0.
  - It is unaffected by `clear`.
- Event detection:
  - `pulse_in` is registered into `pulse_d`.
  - An event is `pulse_in & ~pulse_d`, i.e. a rising edge of `pulse_in`.
  - A level held high for N cycles produces exactly one event.
- Record: the value of `ts` in the cycle the event is detected.
- Pop: `out_valid & out_ready`.
- Push: `event & (level < DEPTH | pop)`. When the FIFO is full and a pop occurs in the same cycle, the event is accepted.
- Drop: `event & level == DEPTH & ~pop`.
  - The record is discarded.
  - `overflow` is set.
  - `event_cnt` is not incremented.
  - Existing entries are never overwritten.
- Counting: `event_cnt` increments on every push and holds at 2^CNT_W−1.
- `clear` has priority over push and pop in the same cycle:
  - FIFO is emptied, `level` = 0.
  - `event_cnt` = 0 and `overflow` = 0.
  - A coincident event is discarded and not counted.
- `out_ts` is meaningful only while `out_valid` = 1. While the FIFO is empty it holds the last-read slot contents (don't-care).

## Timing
- Reset values:
  - `out_valid` = 0, `out_ts` = 0, `level` = 0, `event_cnt` = 0, `overflow` = 0.
  - `ts` = 0, `pulse_d` = 0, holdoff counter = 0.
- Latency: event detected at clock edge k gives `out_valid` = 1 and `level` incremented after edge k. The record is visible one cycle after the first high sample of `pulse_in`.
- Handshake rules:
  - `out_valid` does not depend combinationally on `out_ready`.
  - Once asserted, `out_valid` and `out_ts` stay stable until a pop or `clear`.
  - Back-to-back pops each cycle are supported.
- Simultaneous push and pop: `level` is unchanged and ordering is preserved (FIFO order).
- `reset_n` asserted mid-operation: all state returns to reset values immediately (asynchronous). Buffered records are lost.

## Configuration
- `FALL_EVENT_LOGGER_HOLDOFF_EN` defined:
  - After each push, a down-counter loads `HOLDOFF`−1.
  - Events detected while the counter is non-zero are ignored. They are not stored, not counted, and do not set `overflow`.
  - A `clear` also zeroes the counter.
- Not defined: no holdoff logic is present and every event is processed. The `HOLDOFF` parameter is unused.

## Structure
- Package `fall_event_logger_pkg`:
  - Default-width constants `TS_W_DEF`, `DEPTH_DEF`, `CNT_W_DEF`.
  - Typedef `ts_t` (logic [TS_W_DEF-1:0]).
  - `function clog2_depth`.
- Sub-module `sync_fifo`: parameterised width/depth, one clock, asynchronous active-low reset, synchronous flush. It has push/pop/full/empty/level and registered read data.
- The top level holds the timestamp counter, edge detect, holdoff, counter and overflow logic.

## Test plan
- Reset check: hold `reset_n` = 0 for 2 cycles, then release. Required: `out_valid` = 0, `level` = 0, `event_cnt` = 0, `overflow` = 0.
- Single pulse: `pulse_in` goes high at the edge where `ts` = 10, `out_ready` = 0. Required: next cycle `out_valid` = 1, `out_ts` = 10, `event_cnt` = 1. Raise `out_ready` for 1 cycle; required: `out_valid` = 0, `level` = 0.
- Long level: `pulse_in` high for 20 cycles starting at `ts` = 30. Required: exactly one record, `out_ts` = 30, `event_cnt` = 1.
- Overflow: `DEPTH` = 8, `out_ready` = 0, 10 single-cycle pulses 5 cycles apart. Required: `level` = 8, `event_cnt` = 8, `overflow` = 1. Draining returns the first 8 timestamps in order.
- Full with simultaneous pop: FIFO full, pulse and `out_ready` asserted in the same cycle. Required: `level` stays 8, `overflow` stays 0, `event_cnt` increments, and the new record is last out. Then assert `clear` together with a pulse; required: `level` = 0, `event_cnt` = 0, `overflow` = 0.
- Holdoff: pulses detected 2 cycles apart, `HOLDOFF` = 4. Required: with the macro defined, 1 record; without it, 2 records with timestamps differing by 2.
